mem_interface: RTL and testbench
================================

MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 Parameter TIMEOUT SHALL be: TIMEOUT, default 16, maximum REQ cycles to wait for bus_ack before raising error.
REQ-002 The clock port SHALL be: clk  in  1  the single clock; all logic is on its rising edge.
REQ-003 The reset port SHALL be: rst  in  1  synchronous, active-high reset.
REQ-004 memRead SHALL be: memRead  in  1  load request from control unit.
REQ-005 memWrite SHALL be: memWrite  in  1  store request from control unit.
REQ-006 addr SHALL be: addr  in  32  byte address of the access.
REQ-007 funct3 SHALL be: funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 wdata SHALL be: wdata  in  32  store data, right-justified.
REQ-009 rdata SHALL be: rdata  out  32  registered load result, aligned and extended.
REQ-010 ready SHALL be: ready  out  1  one-cycle completion pulse.
REQ-011 error SHALL be: error  out  1  sticky fault flag, feeds control unit error input.
REQ-012 The bus request outputs SHALL be: bus_req  out  1  request valid; bus_we  out  1  write when 1.
REQ-013 The bus address and data outputs SHALL be: bus_addr  out  32  word-aligned address; bus_be  out  4  byte enables; bus_wdata  out  32  lane-placed store data.
REQ-014 The bus return inputs SHALL be: bus_ack  in  1  access complete; bus_rdata  in  32  raw read word, valid with bus_ack.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, DONE and ERR.
REQ-016 Requests SHALL be sampled only in IDLE; memRead/memWrite in other states SHALL be ignored.
REQ-017 In IDLE, a valid request SHALL latch addr, funct3 and wdata, clear the wait counter and move to REQ.
REQ-018 A request SHALL go to ERR, with no bus_req ever asserted for it, on any of the following:
- memRead and memWrite both high;
- load funct3 in {011, 110, 111};
- store funct3 > 010;
- halfword with addr[0]=1;
- word with addr[1:0]!=00.
REQ-019 In REQ, bus_req SHALL be 1 and bus_we/bus_addr/bus_be/bus_wdata SHALL be held stable from the latched values.
REQ-020 In REQ, bus_addr SHALL equal {addr[31:2], 2'b00}.
REQ-021 In REQ with bus_ack=1, the FSM SHALL capture the extracted load data into rdata (loads only) and move to DONE.
REQ-022 In REQ with bus_ack=0, the counter SHALL increment; reaching TIMEOUT-1 without ack SHALL move the FSM to ERR.
REQ-023 If bus_ack arrives on the same cycle the counter reaches TIMEOUT-1, ack SHALL win.
REQ-024 DONE SHALL assert ready for exactly one cycle and then return to IDLE.
REQ-025 Minimum latency SHALL be request in IDLE at cycle 0, REQ at cycle 1 with ack, ready at cycle 2.
REQ-026 ERR SHALL assert error continuously, keep bus_req=0, and remain in ERR until rst.
REQ-027 Byte enables SHALL be: SB = 4'b0001<<addr[1:0], SH = 4'b0011<<addr[1:0], SW = 4'b1111.
REQ-028 Store data SHALL be: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
REQ-029 Load extraction SHALL select the byte/halfword lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-030 rdata SHALL hold its value until the next completed load; stores SHALL leave rdata unchanged.
REQ-031 bus_ack outside REQ SHALL be ignored.

Reset
REQ-032 rst SHALL force the FSM to IDLE, zero the counter, and set rdata=0, ready=0, error=0, bus_req=0, bus_we=0, bus_be=0.
REQ-033 rst asserted mid-REQ SHALL drop bus_req on the next edge, and a late bus_ack SHALL then be ignored.
REQ-034 rst SHALL override all other inputs on the same edge.

Structure
REQ-035 A shared package SHALL hold the state enum, the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the default TIMEOUT.
REQ-036 A combinational sub-module load_store_align SHALL compute bus_be, bus_wdata and the extracted load data, and the FSM and counter SHALL stay in mem_interface.

Verification
REQ-037 The bench SHALL cover: LW, addr=0x100, bus_ack on first REQ cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_be=1111, ready at cycle 2, rdata=0xDEADBEEF.
REQ-038 The bench SHALL cover: LB, addr=0x103, bus_rdata=0x80FF0011 -> rdata=0xFFFFFF80; the same access as LBU -> rdata=0x00000080.
REQ-039 The bench SHALL cover: SH, addr=0x202, wdata=0x1234ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
REQ-040 The bench SHALL cover: LW, addr=0x101 -> no bus_req, error=1 next cycle and still 1 after 10 cycles; after rst, error=0.
REQ-041 The bench SHALL cover: TIMEOUT=16, LW with bus_ack never asserted -> bus_req high 16 cycles, then error=1, ready never asserted.
REQ-042 The bench SHALL cover: rst on the 3rd REQ cycle with bus_ack the following cycle -> bus_req=0, state IDLE, ready=0, rdata=0.

Source files
------------

// File: rtl/mem_interface_pkg.sv
// Shared types and constants for the load/store bus interface:
// FSM state encoding, RISC-V funct3 access codes and the default ack timeout.
package mem_interface_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_interface_load_store_align.sv
// Combinational lane steering: byte enables and replicated store data for the bus,
// and lane selection plus sign/zero extension for returned load words.
module load_store_align
  import mem_interface_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  function automatic logic [31:0] ext8(input logic signed [7:0] b, input logic zext);
    return zext ? {24'd0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic signed [15:0] h, input logic zext);
    return zext ? {16'd0, h} : {{16{h[15]}}, h};
  endfunction

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = bus_rdata[7:0];
    case (addr_lo)
      2'd0:    byte_lane = bus_rdata[7:0];
      2'd1:    byte_lane = bus_rdata[15:8];
      2'd2:    byte_lane = bus_rdata[23:16];
      default: byte_lane = bus_rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  end

  // funct3[1:0] carries the size for both loads and stores; funct3[2] is the unsigned flag.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    load_data  = bus_rdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        load_data  = ext8(byte_lane, funct3[2]);
      end
      2'b01: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        load_data  = ext16(half_lane, funct3[2]);
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        load_data  = bus_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_interface.sv
// Load/store unit front end: validates a CPU access, runs one bus transaction with
// an ack timeout, and returns an aligned, extended load result with a ready pulse.
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = rd && wr;
    if (rd && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) bad = 1'b1;
    if (wr && (f3 > SW)) bad = 1'b1;
    if (f3[1:0] == 2'b01 && a[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && a != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_p0;
  logic [2:0]    funct3_p0;
  logic [31:0]   wdata_p0;
  logic [3:0]    be_calc;
  logic [31:0]   load_data;
  logic          start;

  assign start = (state == IDLE) && (memRead || memWrite);

  // Request capture stage: access attributes held for the whole bus transaction.
  always_ff @(posedge clk) begin
    if (start) begin
      addr_p0   <= addr;
      funct3_p0 <= funct3;
      wdata_p0  <= wdata;
    end
  end

  load_store_align u_align (
    .funct3     (funct3_p0),
    .addr_lo    (addr_p0[1:0]),
    .wdata      (wdata_p0),
    .bus_rdata  (bus_rdata),
    .be         (be_calc),
    .wdata_lane (bus_wdata),
    .load_data  (load_data)
  );

  assign bus_addr = {addr_p0[31:2], 2'b00};
  assign bus_be   = bus_req ? be_calc : 4'b0000;

  // Bus transaction stage: FSM, wait counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      error   <= 1'b0;
      bus_req <= 1'b0;
      bus_we  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (req_illegal(memRead, memWrite, funct3, addr[1:0])) begin
              error <= 1'b1;
              state <= ERR;
            end else begin
              bus_req <= 1'b1;
              bus_we  <= memWrite;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we) rdata <= load_data;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            ready   <= 1'b1;
            state   <= DONE;
          end else if (cnt == LAST) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            error   <= 1'b1;
            state   <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: begin
          error   <= 1'b1;
          bus_req <= 1'b0;
          bus_we  <= 1'b0;
          state   <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: aligned loads/stores, extension, illegal
// requests, ack timeout boundaries and reset during an outstanding request.
module tb_mem_interface;
  import mem_interface_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        ready, error;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_interface #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .funct3(funct3), .wdata(wdata), .rdata(rdata),
    .ready(ready), .error(error), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd);
    memRead = rd; memWrite = wr; addr = a; funct3 = f3; wdata = wd;
    step();
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  task automatic load_ack(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd);
    start(1'b1, 1'b0, a, f3, 32'h0);
    bus_ack = 1'b1; bus_rdata = rd;
    step();
    bus_ack = 1'b0;
    step();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic illegal(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [2:0] f3);
    start(rd, wr, a, f3, 32'h0);
    chk({tag, "_err"}, 32'(error), 32'd1);
    chk({tag, "_noreq"}, 32'(bus_req), 32'd0);
    pulse_rst();
    chk({tag, "_clr"}, 32'(error), 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; addr = '0; funct3 = '0;
    wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // LW with ack on the first REQ cycle
    start(1'b1, 1'b0, 32'h100, LW, 32'h0);
    chk("lw_req", 32'(bus_req), 32'd1);
    chk("lw_addr", bus_addr, 32'h100);
    chk("lw_be", 32'(bus_be), 32'hF);
    chk("lw_we", 32'(bus_we), 32'd0);
    chk("lw_ready_early", 32'(ready), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    step();
    bus_ack = 1'b0;
    chk("lw_ready", 32'(ready), 32'd1);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("lw_req_drop", 32'(bus_req), 32'd0);
    step();
    chk("lw_ready_pulse", 32'(ready), 32'd0);
    chk("lw_rdata_hold", rdata, 32'hDEADBEEF);

    // Sub-word loads with sign/zero extension
    load_ack(32'h103, LB, 32'h80FF0011);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    load_ack(32'h103, LBU, 32'h80FF0011);
    chk("lbu_rdata", rdata, 32'h00000080);
    load_ack(32'h102, LH, 32'h80FF0011);
    chk("lh_rdata", rdata, 32'hFFFF80FF);
    load_ack(32'h100, LHU, 32'h80FF0011);
    chk("lhu_rdata", rdata, 32'h00000011);

    // SH with one wait cycle; rdata untouched by stores
    start(1'b0, 1'b1, 32'h202, SH, 32'h1234ABCD);
    chk("sh_we", 32'(bus_we), 32'd1);
    chk("sh_be", 32'(bus_be), 32'hC);
    chk("sh_wdata", bus_wdata, 32'hABCDABCD);
    chk("sh_addr", bus_addr, 32'h200);
    memRead = 1'b1; addr = 32'h999;
    step();
    memRead = 1'b0;
    chk("sh_be_stable", 32'(bus_be), 32'hC);
    chk("sh_addr_stable", bus_addr, 32'h200);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("sh_ready", 32'(ready), 32'd1);
    chk("sh_rdata_keep", rdata, 32'h00000011);
    step();

    start(1'b0, 1'b1, 32'h101, SB, 32'h00000055);
    chk("sb_be", 32'(bus_be), 32'h2);
    chk("sb_wdata", bus_wdata, 32'h55555555);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();

    // ack while idle is ignored
    bus_ack = 1'b1;
    repeat (2) step();
    bus_ack = 1'b0;
    chk("idle_ack_ready", 32'(ready), 32'd0);
    chk("idle_ack_req", 32'(bus_req), 32'd0);

    // ack on the final allowed cycle wins over timeout
    start(1'b1, 1'b0, 32'h300, LW, 32'h0);
    repeat (15) step();
    chk("last_req", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    step();
    bus_ack = 1'b0;
    chk("last_ready", 32'(ready), 32'd1);
    chk("last_error", 32'(error), 32'd0);
    chk("last_rdata", rdata, 32'hCAFEF00D);
    step();

    // No ack at all: 16 request cycles then error
    start(1'b1, 1'b0, 32'h304, LW, 32'h0);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && bus_req; i++) begin
      n++;
      if (ready) seen = 1'b1;
      step();
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_error", 32'(error), 32'd1);
    chk("to_no_ready", 32'(seen), 32'd0);
    chk("to_req_low", 32'(bus_req), 32'd0);
    pulse_rst();
    chk("to_rst_clr", 32'(error), 32'd0);

    // Misaligned LW: sticky error, never a bus request
    start(1'b1, 1'b0, 32'h101, LW, 32'h0);
    chk("mis_err", 32'(error), 32'd1);
    seen = bus_req;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_req) seen = 1'b1;
    end
    chk("mis_err_10", 32'(error), 32'd1);
    chk("mis_noreq", 32'(seen), 32'd0);
    pulse_rst();
    chk("mis_rst_clr", 32'(error), 32'd0);

    illegal("both", 1'b1, 1'b1, 32'h100, LW);
    illegal("ld011", 1'b1, 1'b0, 32'h100, 3'b011);
    illegal("ld110", 1'b1, 1'b0, 32'h100, 3'b110);
    illegal("st100", 1'b0, 1'b1, 32'h100, 3'b100);
    illegal("sh_odd", 1'b0, 1'b1, 32'h201, SH);
    illegal("lh_odd", 1'b1, 1'b0, 32'h103, LH);

    // Reset on the third REQ cycle, late ack afterwards
    load_ack(32'h100, LW, 32'h11223344);
    chk("pre_rst_rdata", rdata, 32'h11223344);
    start(1'b1, 1'b0, 32'h400, LW, 32'h0);
    repeat (2) step();
    chk("mid_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_req_drop", 32'(bus_req), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    step();
    bus_ack = 1'b0;
    chk("mid_ready", 32'(ready), 32'd0);
    chk("mid_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rdata", rdata, 32'd0);
    chk("mid_req_idle", 32'(bus_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
